apb2axi_rdf_reader: RTL and testbench
=====================================

Name: apb2axi_rdf_reader

Overview:
Consumer (read side) of the Read Data FIFO. It pops rdf_entry_t beats (tag, 64-bit data, last, resp) produced by the AXI R-channel path. Each beat is split into two 32-bit APB-width words on a valid/ready stream toward the APB read-data register. At each burst end it emits a one-cycle completion summary (tag, beat count, worst resp, error) in completion_entry_t terms.

Parameters:
MAX_BEATS, 16 (apb2axi_pkg::MAX_BEATS_NUM), max beats per burst before forced termination
LO_FIRST, 1, 1: data[31:0] word first; 0: data[63:32] first

Ports:
pclk  in  1  clock
presetn  in  1  reset, asynchronous, active-low
rdf_valid  in  1  RDF non-empty, show-ahead head entry valid
rdf_entry  in  RDF_W  head entry, rdf_entry_t {tag, data, last, resp}
rdf_pop  out  1  pop strobe, one cycle per consumed entry
word_valid  out  1  output word valid
word_ready  in  1  downstream accepts word
word_data  out  APB_DATA_W  32-bit word
word_tag  out  TAG_W  tag of the beat
word_last  out  1  final word of burst
word_resp  out  2  resp of the beat
cpl_valid  out  1  completion pulse, one cycle
cpl_tag  out  TAG_W  burst tag
cpl_beats  out  8  beats in burst (1..MAX_BEATS)
cpl_resp  out  2  worst resp of burst
cpl_error  out  1  error summary

Behaviour:
- Reset (presetn low, async): FSM IDLE; rdf_pop, word_valid, word_last, cpl_valid = 0; word_data, word_tag, word_resp, cpl_* = 0; beat_cnt = 0; in_burst = 0; sticky flags cleared. A beat held at reset is discarded, not popped.
- FSM states: IDLE, W0 (first half), W1 (second half).
- IDLE: if rdf_valid, capture rdf_entry into beat register, assert rdf_pop the same cycle, go W0. Capture and pop always coincide; exactly one pop per captured beat.
- W0: word_valid=1, word_data = LO_FIRST ? data[31:0] : data[63:32], word_last=0. On word_ready, go W1.
- W1: word_valid=1, other half, word_last = captured last (or forced last, see overflow). On word_ready:
  - if rdf_valid, capture next beat, pop, go W0 (no bubble);
  - else go IDLE.
- Throughput: 2 cycles per beat with word_ready held high; first word appears the cycle after capture.
- Holding: word_data/tag/last/resp stable while word_valid && !word_ready. word_valid never drops without a handshake.
- word_tag, word_resp come from the captured beat, identical on both halves.
- Burst tracking, updated at W1 handshake:
  - first beat of burst (in_burst=0) sets burst_tag, beat_cnt=1, in_burst=1; later beats increment beat_cnt (8-bit, never wraps, bounded by MAX_BEATS);
  - worst_resp = numeric max of resp over burst (OKAY 0 < EXOKAY 1 < SLVERR 2 < DECERR 3);
  - tag_mismatch sticky if a later beat tag != burst_tag.
- Overflow: beat reaching beat_cnt==MAX_BEATS with last=0 is treated as last. word_last=1 on its W1 word, and overflow is flagged. The next beat starts a new burst.
- Completion:
  - cpl_valid pulses the cycle after the W1 handshake of a last (or forced-last) beat;
  - cpl_tag=burst_tag, cpl_beats=beat_cnt incl. that beat, cpl_resp=worst_resp;
  - cpl_error = worst_resp[1] | tag_mismatch | overflow;
  - burst state clears in the same update, so a new burst's first beat handshaking in the pulse cycle starts cleanly;
  - cpl_* fields hold until the next pulse.
- Simultaneous: W1 handshake of last beat plus rdf_valid gives next-beat capture and completion update in the same edge, with no lost pop and no lost pulse.
- rdf_entry is sampled only when rdf_pop=1; its value while rdf_valid=0 is ignored.

Test Plan:
- Single beat tag=3, data=64'hAABBCCDD_11223344, last=1, resp=0, ready=1 -> words 32'h11223344 then 32'hAABBCCDD (last=1); one rdf_pop; cpl tag=3 beats=1 resp=0 error=0.
- 4-beat burst tag=5, back-to-back, ready=1 -> 8 words on consecutive cycles, exactly 4 pops, cpl beats=4 one cycle after 8th handshake.
- Same burst with word_ready toggling 1/0 -> word_data stable while stalled, no extra pops, identical word sequence.
- Burst with beat 2 resp=2, beat 3 tag=6 (burst tag 5) -> cpl resp=2, error=1, tag=5.
- 17 beats, none with last -> word_last on beat 16 W1, cpl beats=16 error=1; beat 17 forms a new burst.
- presetn asserted in W1 with rdf_valid=1 -> outputs 0 immediately, no pop during reset; after release, the next entry is captured from IDLE.

Source files
------------

// File: rtl/apb2axi_rdf_reader_if.sv
// Read Data FIFO consumer bus: RDF show-ahead head, APB-width word stream
// and per-burst completion summary.
interface apb2axi_rdf_reader_if #(
    parameter int unsigned TAG_W      = 4,
    parameter int unsigned APB_DATA_W = 32
);
    localparam int unsigned RDF_W = TAG_W + 64 + 1 + 2;

    logic                  rdf_valid;
    logic [RDF_W-1:0]      rdf_entry;
    logic                  rdf_pop;
    logic                  word_valid;
    logic                  word_ready;
    logic [APB_DATA_W-1:0] word_data;
    logic [TAG_W-1:0]      word_tag;
    logic                  word_last;
    logic [1:0]            word_resp;
    logic                  cpl_valid;
    logic [TAG_W-1:0]      cpl_tag;
    logic [7:0]            cpl_beats;
    logic [1:0]            cpl_resp;
    logic                  cpl_error;

    modport master (
        input  rdf_valid, rdf_entry, word_ready,
        output rdf_pop, word_valid, word_data, word_tag, word_last, word_resp,
               cpl_valid, cpl_tag, cpl_beats, cpl_resp, cpl_error
    );

    modport slave (
        output rdf_valid, rdf_entry, word_ready,
        input  rdf_pop, word_valid, word_data, word_tag, word_last, word_resp,
               cpl_valid, cpl_tag, cpl_beats, cpl_resp, cpl_error
    );
endinterface

// File: rtl/apb2axi_rdf_reader.sv
// Pops 64-bit RDF beats, splits each into two 32-bit words and emits a
// one-cycle completion summary at every (real or forced) burst end.
module apb2axi_rdf_reader #(
    parameter int unsigned MAX_BEATS = 16,
    parameter bit          LO_FIRST  = 1'b1,
    parameter int unsigned TAG_W     = 4
) (
    input logic                  pclk,
    input logic                  presetn,
    apb2axi_rdf_reader_if.master bus
);
    typedef enum logic [1:0] {IDLE, W0, W1} state_t;

    state_t           state;
    logic [TAG_W-1:0] b_tag;
    logic [63:0]      b_data;
    logic             b_last;
    logic [1:0]       b_resp;

    logic             in_burst;
    logic [7:0]       beat_cnt;
    logic [TAG_W-1:0] burst_tag;
    logic [1:0]       worst_resp;
    logic             tag_mismatch;

    logic [TAG_W-1:0] e_tag;
    logic [63:0]      e_data;
    logic             e_last;
    logic [1:0]       e_resp;

    logic             take;
    logic [7:0]       cnt_next;
    logic             is_last;
    logic [1:0]       resp_next;
    logic             mism_next;
    logic [TAG_W-1:0] tag_next;

    assign {e_tag, e_data, e_last, e_resp} = bus.rdf_entry;

    // Pop is combinational so it lands on the same edge as the capture;
    // gated by presetn so nothing is popped while reset is held.
    assign take = presetn && bus.rdf_valid &&
                  (state == IDLE || (state == W1 && bus.word_ready));
    assign bus.rdf_pop = take;

    function automatic logic [31:0] half(input logic [63:0] d, input logic first);
        return (first == LO_FIRST) ? d[31:0] : d[63:32];
    endfunction

    always_comb begin
        cnt_next  = in_burst ? beat_cnt + 8'd1 : 8'd1;
        is_last   = b_last || (cnt_next == 8'(MAX_BEATS));
        resp_next = (!in_burst || b_resp > worst_resp) ? b_resp : worst_resp;
        mism_next = in_burst && (tag_mismatch || b_tag != burst_tag);
        tag_next  = in_burst ? burst_tag : b_tag;
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state          <= IDLE;
            b_tag          <= '0;
            b_data         <= '0;
            b_last         <= 1'b0;
            b_resp         <= '0;
            in_burst       <= 1'b0;
            beat_cnt       <= '0;
            burst_tag      <= '0;
            worst_resp     <= '0;
            tag_mismatch   <= 1'b0;
            bus.word_valid <= 1'b0;
            bus.word_data  <= '0;
            bus.word_tag   <= '0;
            bus.word_last  <= 1'b0;
            bus.word_resp  <= '0;
            bus.cpl_valid  <= 1'b0;
            bus.cpl_tag    <= '0;
            bus.cpl_beats  <= '0;
            bus.cpl_resp   <= '0;
            bus.cpl_error  <= 1'b0;
        end else begin
            bus.cpl_valid <= 1'b0;
            case (state)
                W0: if (bus.word_ready) begin
                    bus.word_data <= half(b_data, 1'b0);
                    bus.word_last <= is_last;
                    state         <= W1;
                end
                W1: if (bus.word_ready) begin
                    if (bus.word_last) begin
                        // Forced last (count hit MAX_BEATS without last) is the overflow case.
                        bus.cpl_valid <= 1'b1;
                        bus.cpl_tag   <= tag_next;
                        bus.cpl_beats <= cnt_next;
                        bus.cpl_resp  <= resp_next;
                        bus.cpl_error <= resp_next[1] | mism_next | ~b_last;
                        in_burst      <= 1'b0;
                        beat_cnt      <= '0;
                        worst_resp    <= '0;
                        tag_mismatch  <= 1'b0;
                    end else begin
                        in_burst      <= 1'b1;
                        burst_tag     <= tag_next;
                        beat_cnt      <= cnt_next;
                        worst_resp    <= resp_next;
                        tag_mismatch  <= mism_next;
                    end
                    state          <= IDLE;
                    bus.word_valid <= 1'b0;
                    bus.word_last  <= 1'b0;
                end
                default: ;
            endcase
            // A capture overrides the W1 fall-back to IDLE, giving back-to-back beats.
            if (take) begin
                b_tag          <= e_tag;
                b_data         <= e_data;
                b_last         <= e_last;
                b_resp         <= e_resp;
                bus.word_valid <= 1'b1;
                bus.word_data  <= half(e_data, 1'b1);
                bus.word_tag   <= e_tag;
                bus.word_resp  <= e_resp;
                bus.word_last  <= 1'b0;
                state          <= W0;
            end
        end
    end
endmodule

// File: tb/tb_apb2axi_rdf_reader.sv
// Directed bench for apb2axi_rdf_reader: RDF queue model, ready patterns,
// word/completion scoreboards with hand-computed expectations.
module tb_apb2axi_rdf_reader;
    logic pclk = 1'b0;
    logic presetn;
    always #5 pclk = ~pclk;

    apb2axi_rdf_reader_if #(.TAG_W(4), .APB_DATA_W(32)) bus ();

    apb2axi_rdf_reader #(.MAX_BEATS(16), .LO_FIRST(1'b1), .TAG_W(4)) dut (
        .pclk    (pclk),
        .presetn (presetn),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [70:0] rdf_q[$];
    logic [38:0] exp_w[$];
    logic [38:0] got_w[$];
    int          got_cyc[$];
    logic [14:0] got_c[$];
    int          cpl_cyc[$];
    int          pops = 0;
    int          cycle = 0;
    bit          pop_pending = 1'b0;
    int          ready_mode = 1;
    bit          ready_once = 1'b0;
    bit          ready_tog = 1'b0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    logic        prev_last = 1'b0;
    int          model_cnt = 0;

    // FIFO/ready driver: inputs change only 1 time unit after the rising edge.
    always begin
        @(posedge pclk);
        #1;
        if (pop_pending) begin
            if (rdf_q.size() != 0) void'(rdf_q.pop_front());
            pop_pending = 1'b0;
        end
        bus.rdf_valid = (rdf_q.size() != 0);
        bus.rdf_entry = (rdf_q.size() != 0) ? rdf_q[0] : '0;
        ready_tog = ~ready_tog;
        if (ready_once) begin
            bus.word_ready = 1'b1;
            ready_once     = 1'b0;
        end else begin
            case (ready_mode)
                0:       bus.word_ready = 1'b0;
                1:       bus.word_ready = 1'b1;
                default: bus.word_ready = ready_tog;
            endcase
        end
    end

    always @(negedge pclk) begin
        cycle++;
        if (!presetn) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && bus.word_valid) begin
                check_eq("hold_data", 64'(bus.word_data), 64'(prev_data));
                check_eq("hold_last", 64'(bus.word_last), 64'(prev_last));
            end
            if (bus.rdf_pop) begin
                pop_pending = 1'b1;
                pops++;
            end
            if (bus.word_valid && bus.word_ready) begin
                got_w.push_back({bus.word_last, bus.word_tag, bus.word_resp, bus.word_data});
                got_cyc.push_back(cycle);
            end
            if (bus.cpl_valid) begin
                got_c.push_back({bus.cpl_tag, bus.cpl_beats, bus.cpl_resp, bus.cpl_error});
                cpl_cyc.push_back(cycle);
            end
            prev_stall = bus.word_valid && !bus.word_ready;
            prev_data  = bus.word_data;
            prev_last  = bus.word_last;
        end
    end

    task automatic push_beat(input logic [3:0] tag, input logic [63:0] data,
                             input logic last, input logic [1:0] resp);
        logic l;
        rdf_q.push_back({tag, data, last, resp});
        model_cnt++;
        l = last || (model_cnt == 16);
        if (l) model_cnt = 0;
        exp_w.push_back({1'b0, tag, resp, data[31:0]});
        exp_w.push_back({l, tag, resp, data[63:32]});
    endtask

    task automatic start_test();
        got_w.delete(); exp_w.delete(); got_cyc.delete();
        got_c.delete(); cpl_cyc.delete();
        pops = 0;
        model_cnt = 0;
    endtask

    task automatic wait_done(input string nm, input int nw, input int nc);
        int n = 0;
        while ((got_w.size() < nw || got_c.size() < nc) && n < 400) begin
            @(negedge pclk);
            n++;
        end
        check_eq({nm, "_timeout"}, 64'(n >= 400), 64'd0);
        repeat (4) @(negedge pclk);
        check_eq({nm, "_nwords"}, 64'(got_w.size()), 64'(nw));
        check_eq({nm, "_ncpl"}, 64'(got_c.size()), 64'(nc));
    endtask

    task automatic check_words(input string nm);
        for (int i = 0; i < got_w.size() && i < exp_w.size(); i++)
            check_eq($sformatf("%s_w%0d", nm, i), 64'(got_w[i]), 64'(exp_w[i]));
    endtask

    task automatic check_cpl(input string nm, input int idx, input logic [3:0] t,
                             input logic [7:0] b, input logic [1:0] r, input logic e);
        if (got_c.size() > idx) check_eq(nm, 64'(got_c[idx]), 64'({t, b, r, e}));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int pops_before;
        presetn = 1'b0;
        bus.rdf_valid = 1'b0;
        bus.rdf_entry = '0;
        bus.word_ready = 1'b0;
        repeat (3) @(negedge pclk);
        check_eq("rst_word_valid", 64'(bus.word_valid), 64'd0);
        check_eq("rst_pop", 64'(bus.rdf_pop), 64'd0);
        check_eq("rst_cpl_valid", 64'(bus.cpl_valid), 64'd0);
        check_eq("rst_word_data", 64'(bus.word_data), 64'd0);
        check_eq("rst_cpl_beats", 64'(bus.cpl_beats), 64'd0);
        presetn = 1'b1;

        // Single beat
        start_test();
        ready_mode = 1;
        push_beat(4'd3, 64'hAABBCCDD_11223344, 1'b1, 2'd0);
        wait_done("t1", 2, 1);
        if (got_w.size() == 2) begin
            check_eq("t1_first", 64'(got_w[0]), 64'({1'b0, 4'd3, 2'd0, 32'h11223344}));
            check_eq("t1_second", 64'(got_w[1]), 64'({1'b1, 4'd3, 2'd0, 32'hAABBCCDD}));
        end
        check_eq("t1_pops", 64'(pops), 64'd1);
        check_cpl("t1_cpl", 0, 4'd3, 8'd1, 2'd0, 1'b0);

        // 4-beat back-to-back burst
        start_test();
        for (int i = 0; i < 4; i++)
            push_beat(4'd5, {32'hA000_0000 + 32'(i), 32'h5000_0000 + 32'(i)}, i == 3, 2'd0);
        wait_done("t2", 8, 1);
        check_words("t2");
        check_eq("t2_pops", 64'(pops), 64'd4);
        if (got_cyc.size() == 8 && cpl_cyc.size() == 1) begin
            check_eq("t2_span", 64'(got_cyc[7] - got_cyc[0]), 64'd7);
            check_eq("t2_cpl_lat", 64'(cpl_cyc[0] - got_cyc[7]), 64'd1);
        end
        check_cpl("t2_cpl", 0, 4'd5, 8'd4, 2'd0, 1'b0);

        // Same burst, word_ready toggling
        start_test();
        ready_mode = 2;
        for (int i = 0; i < 4; i++)
            push_beat(4'd5, {32'hA000_0000 + 32'(i), 32'h5000_0000 + 32'(i)}, i == 3, 2'd0);
        wait_done("t3", 8, 1);
        check_words("t3");
        check_eq("t3_pops", 64'(pops), 64'd4);
        check_cpl("t3_cpl", 0, 4'd5, 8'd4, 2'd0, 1'b0);

        // Error resp and tag mismatch inside a burst
        start_test();
        ready_mode = 1;
        push_beat(4'd5, 64'h0000_0001_0000_0002, 1'b0, 2'd0);
        push_beat(4'd5, 64'h0000_0003_0000_0004, 1'b0, 2'd2);
        push_beat(4'd6, 64'h0000_0005_0000_0006, 1'b0, 2'd0);
        push_beat(4'd5, 64'h0000_0007_0000_0008, 1'b1, 2'd0);
        wait_done("t4", 8, 1);
        check_words("t4");
        check_cpl("t4_cpl", 0, 4'd5, 8'd4, 2'd2, 1'b1);

        // 17 beats with no last, then a closing beat
        start_test();
        for (int i = 0; i < 18; i++)
            push_beat(4'd9, {32'hC000_0000 + 32'(i), 32'hD000_0000 + 32'(i)}, i == 17, 2'd0);
        wait_done("t5", 36, 2);
        check_words("t5");
        if (got_w.size() == 36) begin
            check_eq("t5_forced_last", 64'(got_w[31][38]), 64'd1);
            check_eq("t5_b17_not_last", 64'(got_w[33][38]), 64'd0);
        end
        check_cpl("t5_cpl_ovf", 0, 4'd9, 8'd16, 2'd0, 1'b1);
        check_cpl("t5_cpl_next", 1, 4'd9, 8'd2, 2'd0, 1'b0);

        // Reset while sitting in W1 with the next entry waiting
        start_test();
        ready_mode = 0;
        rdf_q.push_back({4'd7, 64'h1111_2222_3333_4444, 1'b0, 2'd0});
        rdf_q.push_back({4'd7, 64'h5555_6666_7777_8888, 1'b1, 2'd0});
        n = 0;
        while (!bus.word_valid && n < 50) begin
            @(negedge pclk);
            n++;
        end
        check_eq("t6_w0_timeout", 64'(n >= 50), 64'd0);
        ready_once = 1'b1;
        @(posedge pclk);
        @(posedge pclk);
        @(negedge pclk);
        check_eq("t6_in_w1_valid", 64'(bus.word_valid), 64'd1);
        check_eq("t6_in_w1_data", 64'(bus.word_data), 64'h1111_2222);
        #1 presetn = 1'b0;
        #1;
        check_eq("t6_rst_valid", 64'(bus.word_valid), 64'd0);
        check_eq("t6_rst_pop", 64'(bus.rdf_pop), 64'd0);
        check_eq("t6_rst_data", 64'(bus.word_data), 64'd0);
        pops_before = pops;
        repeat (2) @(negedge pclk);
        check_eq("t6_rst_no_pop", 64'(pops), 64'(pops_before));
        got_w.delete(); got_cyc.delete(); got_c.delete(); cpl_cyc.delete();
        pops = 0;
        ready_mode = 1;
        @(negedge pclk);
        presetn = 1'b1;
        wait_done("t6", 2, 1);
        if (got_w.size() == 2) begin
            check_eq("t6_first", 64'(got_w[0]), 64'({1'b0, 4'd7, 2'd0, 32'h7777_8888}));
            check_eq("t6_second", 64'(got_w[1]), 64'({1'b1, 4'd7, 2'd0, 32'h5555_6666}));
        end
        check_eq("t6_pops", 64'(pops), 64'd1);
        check_cpl("t6_cpl", 0, 4'd7, 8'd1, 2'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
